// File: rtl/rggen_axi4lite_initiator_pkg.sv
// Shared access encodings, FSM state type and width helper for the
// RgGen AXI4-Lite initiator.
package rggen_axi4lite_initiator_pkg;

  localparam logic [1:0] RGGEN_WRITE = 2'b11;
  localparam logic [1:0] RGGEN_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_RESP,
    READ,
    READ_RESP,
    DONE
  } rggen_state_e;

  // A zero-width ID still needs a one-bit physical port.
  function automatic int rggen_clip_width(int width);
    return (width > 0) ? width : 1;
  endfunction

endpackage

// File: rtl/rggen_axi4lite_initiator.sv
// Bridges the RgGen register bus onto AXI4-Lite, one transaction at a time.
// Requests are captured in IDLE and answered with a one-cycle o_bus_ready.
module rggen_axi4lite_initiator
  import rggen_axi4lite_initiator_pkg::*;
#(
  parameter int ID_WIDTH        = 0,
  parameter int ADDRESS_WIDTH   = 8,
  parameter int BUS_WIDTH       = 32,
  parameter int ACTUAL_ID_WIDTH = rggen_clip_width(ID_WIDTH)
)(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_bus_valid,
  input  logic [1:0]                 i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]   i_bus_address,
  input  logic [BUS_WIDTH-1:0]       i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]     i_bus_strobe,
  output logic                       o_bus_ready,
  output logic [1:0]                 o_bus_status,
  output logic [BUS_WIDTH-1:0]       o_bus_read_data,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_awid,
  output logic [ADDRESS_WIDTH-1:0]   o_awaddr,
  output logic [2:0]                 o_awprot,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  output logic [BUS_WIDTH-1:0]       o_wdata,
  output logic [BUS_WIDTH/8-1:0]     o_wstrb,
  input  logic                       i_bvalid,
  output logic                       o_bready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_bid,
  input  logic [1:0]                 i_bresp,
  output logic                       o_arvalid,
  input  logic                       i_arready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_arid,
  output logic [ADDRESS_WIDTH-1:0]   o_araddr,
  output logic [2:0]                 o_arprot,
  input  logic                       i_rvalid,
  output logic                       o_rready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_rid,
  input  logic [1:0]                 i_rresp,
  input  logic [BUS_WIDTH-1:0]       i_rdata
);

  rggen_state_e               state;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     strobe;
  logic                       write_issued;
  logic                       unused_id;

  assign unused_id = ^{i_bid, i_rid};

  // A channel whose valid already dropped has finished its handshake.
  assign write_issued = (!o_awvalid || i_awready) && (!o_wvalid || i_wready);

  assign o_awid   = '0;
  assign o_arid   = '0;
  assign o_awprot = 3'b000;
  assign o_arprot = 3'b000;
  assign o_awaddr = address;
  assign o_araddr = address;
  assign o_wdata  = write_data;
  assign o_wstrb  = strobe;

  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_bus_valid) begin
      address    <= i_bus_address;
      write_data <= i_bus_write_data;
      strobe     <= i_bus_strobe;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      o_awvalid       <= 1'b0;
      o_wvalid        <= 1'b0;
      o_arvalid       <= 1'b0;
      o_bready        <= 1'b0;
      o_rready        <= 1'b0;
      o_bus_ready     <= 1'b0;
      o_bus_status    <= 2'b00;
      o_bus_read_data <= '0;
    end else begin
      case (state)
        IDLE: if (i_bus_valid) begin
          if (i_bus_access == RGGEN_WRITE) begin
            state     <= WRITE;
            o_awvalid <= 1'b1;
            o_wvalid  <= 1'b1;
          end else begin
            state     <= READ;
            o_arvalid <= 1'b1;
          end
        end
        WRITE: begin
          if (i_awready) o_awvalid <= 1'b0;
          if (i_wready)  o_wvalid  <= 1'b0;
          if (write_issued) begin
            state    <= WRITE_RESP;
            o_bready <= 1'b1;
          end
        end
        WRITE_RESP: if (i_bvalid) begin
          state           <= DONE;
          o_bready        <= 1'b0;
          o_bus_ready     <= 1'b1;
          o_bus_status    <= i_bresp;
          o_bus_read_data <= '0;
        end
        READ: if (i_arready) begin
          state     <= READ_RESP;
          o_arvalid <= 1'b0;
          o_rready  <= 1'b1;
        end
        READ_RESP: if (i_rvalid) begin
          state           <= DONE;
          o_rready        <= 1'b0;
          o_bus_ready     <= 1'b1;
          o_bus_status    <= i_rresp;
          o_bus_read_data <= i_rdata;
        end
        DONE: begin
          state       <= IDLE;
          o_bus_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_axi4lite_initiator.sv
// Randomized bench for rggen_axi4lite_initiator: a delay-configurable AXI
// slave plus a latency/response model derived from the bus-level rules.
module tb_rggen_axi4lite_initiator;
  import rggen_axi4lite_initiator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bus_valid = 1'b0;
  logic [1:0]  bus_access = 2'b00;
  logic [7:0]  bus_address = '0;
  logic [31:0] bus_write_data = '0;
  logic [3:0]  bus_strobe = '0;
  logic        bus_ready;
  logic [1:0]  bus_status;
  logic [31:0] bus_read_data;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [0:0]  awid, arid, bid = '0, rid = '0;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;

  int tests = 0, fails = 0;

  // slave configuration and observations
  int daw, dw, db, dar, dr;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int aw_hs, w_hs, b_hs, ar_hs, r_hs, drop_err, side_err;
  bit hs_aw, hs_w, hs_ar;
  logic [7:0]  aw_addr_seen, ar_addr_seen;
  logic [31:0] wdata_seen;
  logic [3:0]  wstrb_seen;

  always #5 clk = ~clk;

  rggen_axi4lite_initiator dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_valid(bus_valid), .i_bus_access(bus_access), .i_bus_address(bus_address),
    .i_bus_write_data(bus_write_data), .i_bus_strobe(bus_strobe),
    .o_bus_ready(bus_ready), .o_bus_status(bus_status), .o_bus_read_data(bus_read_data),
    .o_awvalid(awvalid), .i_awready(awready), .o_awid(awid), .o_awaddr(awaddr), .o_awprot(awprot),
    .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
    .i_bvalid(bvalid), .o_bready(bready), .i_bid(bid), .i_bresp(bresp),
    .o_arvalid(arvalid), .i_arready(arready), .o_arid(arid), .o_araddr(araddr), .o_arprot(arprot),
    .i_rvalid(rvalid), .o_rready(rready), .i_rid(rid), .i_rresp(rresp), .i_rdata(rdata)
  );

  // AXI slave: decides readies/valids at the falling edge, so every
  // handshake it predicts happens on the following rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
        {hs_aw, hs_w, hs_ar} = '0;
        continue;
      end
      if (hs_aw && awvalid) drop_err++;
      if (hs_w  && wvalid)  drop_err++;
      if (hs_ar && arvalid) drop_err++;
      bid = 1'($urandom); rid = 1'($urandom);
      if (awvalid) begin awready = (aw_wait >= daw); if (aw_wait < daw) aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= dw); if (w_wait < dw) w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      if (arvalid) begin arready = (ar_wait >= dar); if (ar_wait < dar) ar_wait++; end
      else begin arready = 1'b0; ar_wait = 0; end
      if (bready) begin bvalid = (b_wait >= db); bresp = bresp_cfg; if (b_wait < db) b_wait++; end
      else begin bvalid = 1'b0; b_wait = 0; end
      if (rready) begin rvalid = (r_wait >= dr); rresp = rresp_cfg; rdata = rdata_cfg; if (r_wait < dr) r_wait++; end
      else begin rvalid = 1'b0; r_wait = 0; end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_ar = arvalid && arready;
      if (hs_aw) begin aw_hs++; aw_addr_seen = awaddr; if (awid !== 1'b0 || awprot !== 3'b000) side_err++; end
      if (hs_w)  begin w_hs++; wdata_seen = wdata; wstrb_seen = wstrb; end
      if (hs_ar) begin ar_hs++; ar_addr_seen = araddr; if (arid !== 1'b0 || arprot !== 3'b000) side_err++; end
      if (bvalid && bready) b_hs++;
      if (rvalid && rready) r_hs++;
    end
  end

  // Reference: 3 cycles minimum, plus every cycle any channel stalls.
  function automatic int exp_latency(bit wr);
    return wr ? 3 + ((daw > dw) ? daw : dw) + db : 3 + dar + dr;
  endfunction

  task automatic set_slave(int a, int w, int b, int ar, int r);
    daw = a; dw = w; db = b; dar = ar; dr = r;
  endtask

  task automatic issue(bit wr, logic [7:0] a, logic [31:0] d, logic [3:0] s);
    {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
    bus_valid = 1'b1;
    bus_access = wr ? RGGEN_WRITE : RGGEN_READ;
    bus_address = a; bus_write_data = d; bus_strobe = s;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk); #1; lat++;
      if (bus_ready) return;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({awvalid, wvalid, arvalid, bready, rready, bus_ready} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, bus_ready});
    end
    tests++;
    if (bus_status !== 2'b00 || bus_read_data !== 32'h0) begin
      fails++; $display("FAIL reset_resp got %b/%h want 00/00000000", bus_status, bus_read_data);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_write_zero_wait;
    int lat;
    set_slave(0, 0, 0, 0, 0); bresp_cfg = 2'b00;
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    wait_ready(lat);
    bus_valid = 1'b0;
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL wr0_latency got %0d want 3", lat); end
    tests++;
    if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1) begin
      fails++; $display("FAIL wr0_handshakes got aw%0d w%0d b%0d want 1 1 1", aw_hs, w_hs, b_hs);
    end
    tests++;
    if ({aw_addr_seen, wdata_seen, wstrb_seen} !== {8'h10, 32'hDEADBEEF, 4'hF}) begin
      fails++; $display("FAIL wr0_payload got %h %h %h want 10 deadbeef f", aw_addr_seen, wdata_seen, wstrb_seen);
    end
    tests++;
    if (bus_status !== 2'b00 || bus_read_data !== 32'h0) begin
      fails++; $display("FAIL wr0_resp got %b/%h want 00/0", bus_status, bus_read_data);
    end
    @(negedge clk); #1;
    tests++;
    if (bus_ready !== 1'b0) begin fails++; $display("FAIL wr0_pulse got %b want 0", bus_ready); end
  endtask

  task automatic test_write_stall;
    int lat, pulses;
    set_slave(2, 0, 4, 0, 0); bresp_cfg = 2'b11;
    drop_err = 0;
    issue(1'b1, 8'h3C, 32'h0BAD_F00D, 4'h5);
    wait_ready(lat);
    bus_valid = 1'b0;
    tests++;
    if (lat !== exp_latency(1'b1)) begin fails++; $display("FAIL wrs_latency got %0d want %0d", lat, exp_latency(1'b1)); end
    tests++;
    if (drop_err !== 0 || aw_hs !== 1 || w_hs !== 1) begin
      fails++; $display("FAIL wrs_valid_drop got drops%0d aw%0d w%0d want 0 1 1", drop_err, aw_hs, w_hs);
    end
    tests++;
    if (bus_status !== 2'b11) begin fails++; $display("FAIL wrs_status got %b want 11", bus_status); end
    pulses = 0;
    repeat (4) begin @(negedge clk); #1; if (bus_ready) pulses++; end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL wrs_single_pulse got %0d extra want 0", pulses); end
  endtask

  task automatic test_read;
    int lat;
    set_slave(0, 0, 0, 0, 0); rresp_cfg = 2'b10; rdata_cfg = 32'h12345678;
    issue(1'b0, 8'h24, 32'hFFFF_FFFF, 4'h0);
    wait_ready(lat);
    bus_valid = 1'b0;
    tests++;
    if (lat !== 3 || ar_hs !== 1 || ar_addr_seen !== 8'h24) begin
      fails++; $display("FAIL rd_ar got lat%0d ar%0d addr%h want 3 1 24", lat, ar_hs, ar_addr_seen);
    end
    tests++;
    if (bus_read_data !== 32'h12345678 || bus_status !== 2'b10) begin
      fails++; $display("FAIL rd_resp got %h/%b want 12345678/10", bus_read_data, bus_status);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    set_slave(0, 0, 0, 0, 0); rresp_cfg = 2'b00; rdata_cfg = 32'hA5A5_0001; bresp_cfg = 2'b01;
    issue(1'b0, 8'h40, 32'h0, 4'h0);
    wait_ready(lat1);
    issue(1'b1, 8'h44, 32'hCAFE_0002, 4'h3);
    @(negedge clk); #1;
    tests++;
    if ({awvalid, wvalid, arvalid, bus_ready} !== 4'b0) begin
      fails++; $display("FAIL b2b_done_ignored got %b want 0000", {awvalid, wvalid, arvalid, bus_ready});
    end
    wait_ready(lat2);
    bus_valid = 1'b0;
    tests++;
    if (lat1 !== 3 || lat2 !== 3) begin fails++; $display("FAIL b2b_latency got %0d,%0d want 3,3", lat1, lat2); end
    tests++;
    if (ar_hs !== 0 || aw_hs !== 1 || aw_addr_seen !== 8'h44 || bus_status !== 2'b01) begin
      fails++; $display("FAIL b2b_second got ar%0d aw%0d addr%h st%b want 0 1 44 01", ar_hs, aw_hs, aw_addr_seen, bus_status);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_midflight;
    int lat;
    set_slave(30, 0, 0, 0, 0); bresp_cfg = 2'b00;
    issue(1'b1, 8'h80, 32'h1111_2222, 4'hF);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (awvalid !== 1'b1 || wvalid !== 1'b0) begin
      fails++; $display("FAIL rst_pre got aw%b w%b want 1 0", awvalid, wvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({awvalid, wvalid, arvalid, bready, rready, bus_ready} !== 6'b0) begin
      fails++; $display("FAIL rst_async got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, bus_ready});
    end
    bus_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({awvalid, wvalid, arvalid, bus_ready} !== 4'b0) begin
      fails++; $display("FAIL rst_idle got %b want 0000", {awvalid, wvalid, arvalid, bus_ready});
    end
    set_slave(0, 0, 0, 0, 0); bresp_cfg = 2'b10;
    issue(1'b1, 8'h84, 32'h3333_4444, 4'hC);
    wait_ready(lat);
    bus_valid = 1'b0;
    tests++;
    if (lat !== 3 || bus_status !== 2'b10 || wdata_seen !== 32'h3333_4444 || aw_addr_seen !== 8'h84) begin
      fails++; $display("FAIL rst_recover got lat%0d st%b d%h a%h want 3 10 33334444 84", lat, bus_status, wdata_seen, aw_addr_seen);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_random;
    int lat;
    bit wr;
    logic [7:0] a; logic [31:0] d, exp_data; logic [3:0] s; logic [1:0] exp_st;
    drop_err = 0; side_err = 0;
    for (int n = 0; n < 24; n++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom); rdata_cfg = $urandom;
      wr = 1'($urandom); a = 8'($urandom); d = $urandom; s = 4'($urandom);
      exp_st = wr ? bresp_cfg : rresp_cfg;
      exp_data = wr ? 32'h0 : rdata_cfg;
      issue(wr, a, d, s);
      wait_ready(lat);
      bus_valid = 1'b0;
      tests++;
      if (lat !== exp_latency(wr)) begin fails++; $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, exp_latency(wr)); end
      tests++;
      if (bus_status !== exp_st || bus_read_data !== exp_data) begin
        fails++; $display("FAIL rnd%0d_resp got %b/%h want %b/%h", n, bus_status, bus_read_data, exp_st, exp_data);
      end
      tests++;
      if (wr ? (aw_hs !== 1 || w_hs !== 1 || ar_hs !== 0 || aw_addr_seen !== a || wdata_seen !== d || wstrb_seen !== s)
             : (ar_hs !== 1 || aw_hs !== 0 || w_hs !== 0 || ar_addr_seen !== a)) begin
        fails++; $display("FAIL rnd%0d_axi got aw%0d w%0d ar%0d a%h/%h d%h s%h want wr%0d a%h d%h s%h",
                          n, aw_hs, w_hs, ar_hs, aw_addr_seen, ar_addr_seen, wdata_seen, wstrb_seen, wr, a, d, s);
      end
      @(negedge clk); #1;
      tests++;
      if (bus_ready !== 1'b0) begin fails++; $display("FAIL rnd%0d_pulse got %b want 0", n, bus_ready); end
    end
    tests++;
    if (drop_err !== 0 || side_err !== 0) begin
      fails++; $display("FAIL rnd_protocol got drops%0d id_prot%0d want 0 0", drop_err, side_err);
    end
  endtask

  initial begin
    set_slave(0, 0, 0, 0, 0);
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = '0;
    drop_err = 0; side_err = 0;
    #1;
    test_reset();
    test_write_zero_wait();
    test_write_stall();
    test_read();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rggen_axi4lite_initiator.md
RGGEN_AXI4LITE_INITIATOR -- requirements
Module: rggen_axi4lite_initiator

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 0, AXI ID width (0 = no ID bits).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, bus/AXI address width.
REQ-003 SHALL have parameter BUS_WIDTH, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter ACTUAL_ID_WIDTH, default rggen_clip_width(ID_WIDTH), physical ID port width (min 1).
REQ-005 SHALL have i_clk  input  1  clock.
REQ-006 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have i_bus_valid  input  1  request valid, held by requester until o_bus_ready.
REQ-008 SHALL have i_bus_access  input  2  2'b11 write, 2'b10 read.
REQ-009 SHALL have i_bus_address / i_bus_write_data / i_bus_strobe  input  ADDRESS_WIDTH / BUS_WIDTH / BUS_WIDTH/8  request payload.
REQ-010 SHALL have o_bus_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have o_bus_status / o_bus_read_data  output  2 / BUS_WIDTH  completion status and read data, valid with o_bus_ready.
REQ-012 SHALL have o_awvalid, i_awready, o_awid, o_awaddr, o_awprot(3)  AXI AW channel, widths per parameters.
REQ-013 SHALL have o_wvalid, i_wready, o_wdata, o_wstrb  AXI W channel.
REQ-014 SHALL have i_bvalid, o_bready, i_bid, i_bresp(2)  AXI B channel.
REQ-015 SHALL have o_arvalid, i_arready, o_arid, o_araddr, o_arprot(3)  AXI AR channel.
REQ-016 SHALL have i_rvalid, o_rready, i_rid, i_rresp(2), i_rdata  AXI R channel.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, WRITE_RESP, READ, READ_RESP, DONE; one transaction outstanding at a time.
REQ-018 SHALL, in IDLE with i_bus_valid=1, capture access/address/write_data/strobe into registers and go to WRITE (access 2'b11) or READ (2'b10).
REQ-019 SHALL assert o_awvalid and o_wvalid together on entry to WRITE, driving captured address/data/strobe; payload stable while valid.
REQ-020 SHALL track AW and W handshakes independently; each valid drops the cycle after its own handshake; AW and W handshakes in the same or different cycles both supported.
REQ-021 SHALL go WRITE->WRITE_RESP once both AW and W handshakes have completed; o_bready=1 only in WRITE_RESP.
REQ-022 SHALL assert o_arvalid in READ with captured address; go READ->READ_RESP after AR handshake; o_rready=1 only in READ_RESP.
REQ-023 SHALL, on B (R) handshake, register bresp (rresp, rdata) and go to DONE.
REQ-024 SHALL in DONE drive o_bus_ready=1 for exactly one cycle with o_bus_status=captured resp, o_bus_read_data=captured rdata (all-zero for writes), then return to IDLE.
REQ-025 SHALL ignore i_bus_valid in every state except IDLE, including the DONE cycle.
REQ-026 SHALL drive o_awid/o_arid all-zero and o_awprot/o_arprot 3'b000; i_bid/i_rid ignored.
REQ-027 SHALL pass addresses unmodified (no alignment or range check).
REQ-028 SHALL give minimum latency 3 cycles from i_bus_valid to o_bus_ready (zero-wait slave); AXI stalls extend it cycle for cycle, no timeout.
REQ-029 SHALL drive o_bus_ready low and all AXI valids/readies low in IDLE.

Reset
REQ-030 SHALL on i_rst_n=0 immediately force state IDLE and o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_bus_ready to 0, o_bus_status 2'b00, o_bus_read_data 0, aborting any transaction mid-flight.
REQ-031 SHALL not require reset on captured payload registers other than those in REQ-030.

Structure
REQ-032 SHALL take access encodings (RGGEN_WRITE=2'b11, RGGEN_READ=2'b10), FSM state encoding and rggen_clip_width from the shared rggen macros/package.
REQ-033 SHALL be a single module, no sub-modules.

Verification
REQ-034 SHALL verify write addr 8'h10, data 32'hDEADBEEF, strobe 4'hF, slave zero-wait, bresp 2'b00 -> AW/W once, o_bus_ready 3 cycles after valid, status 2'b00.
REQ-035 SHALL verify write with i_wready 2 cycles before i_awready and bvalid delayed 4 cycles -> each valid drops after its own handshake, single ready pulse, status from bresp.
REQ-036 SHALL verify read addr 8'h24, rdata 32'h12345678, rresp 2'b10 -> o_bus_read_data 32'h12345678, o_bus_status 2'b10.
REQ-037 SHALL verify back-to-back read then write with i_bus_valid held -> no request accepted in DONE cycle, second transaction starts next IDLE.
REQ-038 SHALL verify i_rst_n asserted while o_awvalid=1 awaiting i_awready -> all valids low immediately, IDLE after release, next request completes normally.
